// File: rtl/tone_gen_multi_if.sv
// tone_gen_multi_if: CPU write port and tone outputs of the multi-channel tone generator.
interface tone_gen_multi_if #(
    parameter int CHANNELS = 4,
    parameter int PERIOD_W = 20,
    parameter int DUR_W    = 16
);
    logic                        wr_en;
    logic [$clog2(CHANNELS)-1:0] wr_chan;
    logic [PERIOD_W-1:0]         wr_half_period;
    logic [DUR_W-1:0]            wr_duration;
    logic [CHANNELS-1:0]         busy;
    logic [CHANNELS-1:0]         done;
    logic [CHANNELS-1:0]         tone;
    logic                        buzzer;

    modport master (
        output wr_en, wr_chan, wr_half_period, wr_duration,
        input  busy, done, tone, buzzer
    );
    modport slave (
        input  wr_en, wr_chan, wr_half_period, wr_duration,
        output busy, done, tone, buzzer
    );
endinterface

// File: rtl/tone_gen_multi.sv
// tone_gen_multi: per-channel square-wave tone generators with ms-style durations
// and a first-order sigma-delta PDM mix onto a single buzzer pin.
module tone_gen_multi #(
    parameter int CHANNELS = 4,
    parameter int PERIOD_W = 20,
    parameter int DUR_W    = 16,
    parameter int TICK_DIV = 50000
) (
    input logic               clk,
    input logic               rst_async,
    tone_gen_multi_if.slave   bus
);
    localparam int CW = $clog2(CHANNELS);
    localparam int AW = $clog2(CHANNELS) + 1;
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;
    logic [AW-1:0] r_acc;
    logic [AW-1:0] w_sum;
    logic [AW-1:0] w_a;
    logic          r_buzzer;

    assign w_tick = r_tick_cnt == TW'(TICK_DIV - 1);

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) r_tick_cnt <= '0;
        else           r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic                r_active;
        logic                r_tgl;
        logic                r_done;
        logic [PERIOD_W-1:0] r_half;
        logic [PERIOD_W-1:0] r_cnt;
        logic [DUR_W-1:0]    r_rem;
        logic                w_wr;

        assign w_wr = bus.wr_en && bus.wr_chan == CW'(i);

        // A write takes priority over an expiry landing on the same edge.
        always_ff @(posedge clk or posedge rst_async) begin
            if (rst_async) begin
                r_active <= 1'b0;
                r_tgl    <= 1'b0;
                r_done   <= 1'b0;
                r_half   <= '0;
                r_cnt    <= '0;
                r_rem    <= '0;
            end else begin
                r_done <= 1'b0;
                if (w_wr) begin
                    r_tgl <= 1'b0;
                    r_rem <= bus.wr_half_period != '0 ? bus.wr_duration : '0;
                    r_active <= bus.wr_half_period != '0;
                    if (bus.wr_half_period != '0) begin
                        r_half <= bus.wr_half_period;
                        r_cnt  <= '0;
                    end
                end else if (r_active) begin
                    if (w_tick && r_rem == DUR_W'(1)) begin
                        r_active <= 1'b0;
                        r_tgl    <= 1'b0;
                        r_rem    <= '0;
                        r_done   <= 1'b1;
                    end else begin
                        if (w_tick && r_rem != '0) r_rem <= r_rem - DUR_W'(1);
                        r_cnt <= r_cnt == r_half - PERIOD_W'(1) ? '0 : r_cnt + PERIOD_W'(1);
                        if (r_cnt == r_half - PERIOD_W'(1)) r_tgl <= ~r_tgl;
                    end
                end
            end
        end

        // Toggle is always cleared alongside active, so it already equals toggle & active.
        assign bus.busy[i] = r_active;
        assign bus.done[i] = r_done;
        assign bus.tone[i] = r_tgl;
    end

    always_comb begin
        w_sum = '0;
        for (int j = 0; j < CHANNELS; j++) w_sum = w_sum + AW'(bus.tone[j]);
    end

    assign w_a = r_acc + w_sum;

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_acc    <= '0;
            r_buzzer <= 1'b0;
        end else begin
            r_buzzer <= w_a >= AW'(CHANNELS);
            r_acc    <= w_a >= AW'(CHANNELS) ? w_a - AW'(CHANNELS) : w_a;
        end
    end

    assign bus.buzzer = r_buzzer;
endmodule

// File: tb/tb_tone_gen_multi.sv
// tb_tone_gen_multi: directed and random checks of tone_gen_multi against a timing-rule model.
module tb_tone_gen_multi;
    localparam int C  = 4;
    localparam int PW = 20;
    localparam int DW = 16;
    localparam int TD = 10;

    logic clk = 1'b0;
    logic rst_async = 1'b0;
    always #5 clk = ~clk;

    tone_gen_multi_if #(.CHANNELS(C), .PERIOD_W(PW), .DUR_W(DW)) bus ();
    tone_gen_multi #(.CHANNELS(C), .PERIOD_W(PW), .DUR_W(DW), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_async(rst_async), .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int n = 0;
    int s_tot = 0;
    logic m_act [C];
    int m_k [C];
    int m_h [C];
    int m_exp [C];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic m_busy(input int c);
        return m_act[c] && !(m_exp[c] != 0 && n >= m_exp[c]);
    endfunction

    function automatic logic [C-1:0] e_busy();
        logic [C-1:0] v;
        for (int c = 0; c < C; c++) v[c] = m_busy(c);
        return v;
    endfunction

    function automatic logic [C-1:0] e_tone();
        logic [C-1:0] v;
        for (int c = 0; c < C; c++) v[c] = m_busy(c) ? (((n - m_k[c]) / m_h[c]) % 2 == 1) : 1'b0;
        return v;
    endfunction

    function automatic logic [C-1:0] e_done();
        logic [C-1:0] v;
        for (int c = 0; c < C; c++) v[c] = m_act[c] && m_exp[c] != 0 && n == m_exp[c];
        return v;
    endfunction

    function automatic int pop(input logic [C-1:0] v);
        int s = 0;
        for (int c = 0; c < C; c++) s += int'(v[c]);
        return s;
    endfunction

    task automatic model_clear();
        n = 0;
        s_tot = 0;
        for (int c = 0; c < C; c++) begin
            m_act[c] = 1'b0; m_k[c] = 0; m_h[c] = 1; m_exp[c] = 0;
        end
    endtask

    // Buzzer ones so far must equal floor(total tone-sum / C).
    task automatic tick();
        int s;
        int c;
        s = pop(e_tone());
        @(posedge clk);
        #1;
        n++;
        s_tot += s;
        if (bus.wr_en) begin
            c = int'(bus.wr_chan);
            if (bus.wr_half_period != 0) begin
                m_act[c] = 1'b1;
                m_k[c] = n;
                m_h[c] = int'(bus.wr_half_period);
                m_exp[c] = bus.wr_duration == 0 ? 0 : ((n / TD) + 1) * TD + (int'(bus.wr_duration) - 1) * TD;
            end else m_act[c] = 1'b0;
        end
        bus.wr_en = 1'b0;
        chk("busy", 32'(bus.busy), 32'(e_busy()));
        chk("done", 32'(bus.done), 32'(e_done()));
        chk("tone", 32'(bus.tone), 32'(e_tone()));
        chk("buzzer", 32'(bus.buzzer), 32'((s_tot / C) != ((s_tot - s) / C)));
    endtask

    task automatic write(input int c, input int h, input int d);
        bus.wr_en = 1'b1;
        bus.wr_chan = 2'(c);
        bus.wr_half_period = PW'(h);
        bus.wr_duration = DW'(d);
        tick();
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic count_buzz(input int k, output int ones);
        ones = 0;
        for (int i = 0; i < k; i++) begin
            tick();
            ones += int'(bus.buzzer);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2;
        rst_async = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_tone", 32'(bus.tone), 0);
        chk("rst_buzzer", 32'(bus.buzzer), 0);
        @(negedge clk);
        rst_async = 1'b0;
        model_clear();
    endtask

    initial begin
        int pat [7] = '{0, 0, 0, 1, 1, 1, 0};
        int cnt;
        int ones;
        int target;
        bus.wr_en = 1'b0;
        bus.wr_chan = '0;
        bus.wr_half_period = '0;
        bus.wr_duration = '0;
        model_clear();
        #1;
        reset_pulse();
        run(3);

        write(0, 3, 0);
        chk("hp_tone0", 32'(bus.tone[0]), 32'(pat[0]));
        for (int i = 1; i < 7; i++) begin
            tick();
            chk("hp_tone", 32'(bus.tone[0]), 32'(pat[i]));
        end
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cnt += int'(bus.done[0]);
        end
        chk("hp_no_done", 32'(cnt), 0);
        chk("hp_busy", 32'(bus.busy[0]), 1);
        write(0, 0, 0);

        write(1, 2, 3);
        cnt = 0;
        for (int i = 0; i < 60 && bus.busy[1]; i++) begin
            tick();
            cnt += int'(bus.done[1]);
        end
        chk("timed_drop", 32'(bus.busy[1]), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            cnt += int'(bus.done[1]);
        end
        chk("timed_done_once", 32'(cnt), 1);
        chk("timed_tone", 32'(bus.tone[1]), 0);

        write(1, 4, 0);
        run(5);
        write(1, 0, 0);
        chk("stop_busy", 32'(bus.busy[1]), 0);
        chk("stop_done", 32'(bus.done[1]), 0);
        write(1, 3, 0);
        run(2);
        write(1, 5, 0);
        run(4);
        chk("retrig_low", 32'(bus.tone[1]), 0);
        tick();
        chk("retrig_high", 32'(bus.tone[1]), 1);
        write(1, 0, 0);

        write(2, 3, 1);
        target = m_exp[2];
        while (n + 1 < target) tick();
        write(2, 4, 0);
        chk("coll_busy", 32'(bus.busy[2]), 1);
        chk("coll_done", 32'(bus.done[2]), 0);
        run(12);
        write(2, 0, 0);

        write(0, 150, 0);
        write(1, 150, 0);
        run(152);
        count_buzz(100, ones);
        chk("mix_half", 32'(ones), 50);
        for (int c = 0; c < C; c++) write(c, 0, 0);
        for (int c = 0; c < C; c++) write(c, 150, 0);
        run(152);
        count_buzz(100, ones);
        chk("mix_full", 32'(ones), 100);
        for (int c = 0; c < C; c++) write(c, 0, 0);
        run(2);
        count_buzz(100, ones);
        chk("mix_zero", 32'(ones), 0);

        write(3, 2, 0);
        run(5);
        reset_pulse();
        run(20);
        chk("post_rst_idle", 32'(bus.busy), 0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0)
                write(int'($urandom_range(0, C - 1)),
                      $urandom_range(0, 5) == 0 ? 0 : int'($urandom_range(1, 6)),
                      int'($urandom_range(0, 4)));
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
